axi4lite_master_port: RTL and testbench

- Single-outstanding AXI4-Lite initiator: the master-side counterpart to the team's AXI4-Lite slave IP.
- Accepts one read or write command on a simple valid/ready command channel and drives the AW/W/B or AR/R channels.
- Returns the read data and response code on a valid/ready response channel.
- Used by test harnesses and by generated IP that must access other AXI4-Lite peripherals.

---
 rtl/axi4lite_master_port_pkg.sv | 20 ++
 rtl/axi4lite_master_port.sv | 209 ++++++++++++++++++++
 tb/tb_axi4lite_master_port.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_master_port_pkg.sv
// rtl/axi4lite_master_port_pkg.sv - shared response codes and FSM encoding for the AXI4-Lite master port
package axi4lite_master_port_pkg;

  // AXI response codes as they appear on BRESP/RRESP
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Transaction phases of the single-outstanding initiator
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESP         = 3'd5
  } state_e;

endpackage

// File: rtl/axi4lite_master_port.sv
// rtl/axi4lite_master_port.sv - single-outstanding AXI4-Lite initiator with cmd/rsp valid-ready channels
module axi4lite_master_port
  import axi4lite_master_port_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                      clk,
  input  logic                      resetn,
  // command channel
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response channel
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // AXI write address
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  // AXI write response
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // AXI read address
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  // holding registers: the AXI address/data outputs come straight from these,
  // so they cannot move while a valid is waiting for its ready
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;

  // Next-state and next-output computation for the transaction FSM
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready rises one clock after reset release or after a response handshake
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end

      ST_WR_ADDR_DATA: begin
        // AW and W retire independently; move on only once both are gone
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RD_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        // response codes are passed through untouched, error or not
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awaddr    = addr_q;
  assign awprot    = PROT;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = addr_q;
  assign arprot    = PROT;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axi4lite_master_port.sv
// tb/tb_axi4lite_master_port.sv - randomized scoreboard bench for the AXI4-Lite master port
module tb_axi4lite_master_port;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  axi4lite_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } cmd_t;
  cmd_t cmd_q[$];

  // slave behaviour knobs (fixed values for directed cases, drawn per transaction in random mode)
  bit          run_en = 0, cfg_rand = 0;
  int          cfg_aw = 0, cfg_w = 0, cfg_ar = 0, cfg_b = 0, cfg_r = 0, cfg_hold = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  // transaction-level model of the initiator
  bit          busy = 0, is_wr = 0, aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0;
  bit          rsp_pend = 0, b_armed = 0, r_armed = 0;
  logic [31:0] cur_addr, cur_wdata, cur_rdata, exp_rdata;
  logic [3:0]  cur_wstrb;
  logic [1:0]  cur_bresp, cur_rresp, exp_resp;
  int          d_aw, d_w, d_ar, d_b, d_r, d_hold, gap = 0;
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait, rsp_wait;
  int          n_done = 0;

  // observations for the directed cases
  int          accept_edge = 0, first_aw = -1, first_br = -1, b_hs = -1, rsp_first = -1, rsp_hs = -100;
  int          aw_hi = 0, w_hi = 0, rsp_hi = 0, last_rsp_hi = 0, accept_gap = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr, last_rsp_rdata;
  logic [1:0]  last_rsp_resp;

  // per-cycle compare against the model, then slave/command driving, then model update
  initial begin
    forever begin
      @(negedge clk);
      if (!run_en) begin
        cmd_valid = 0; awready = 0; wready = 0; arready = 0;
        bvalid = 0; rvalid = 0; rsp_ready = 0;
        continue;
      end
      chk("cmd_ready", cmd_ready, !busy);
      chk("awvalid", awvalid, busy && is_wr && !aw_done);
      chk("wvalid", wvalid, busy && is_wr && !w_done);
      chk("bready", bready, busy && is_wr && aw_done && w_done && !b_done);
      chk("arvalid", arvalid, busy && !is_wr && !ar_done);
      chk("rready", rready, busy && !is_wr && ar_done && !r_done);
      chk("rsp_valid", rsp_valid, rsp_pend);
      if (busy && is_wr && !aw_done) begin
        chk("awaddr", awaddr, cur_addr);
        chk("awprot", awprot, 3'b000);
      end
      if (busy && is_wr && !w_done) begin
        chk("wdata", wdata, cur_wdata);
        chk("wstrb", wstrb, cur_wstrb);
      end
      if (busy && !is_wr && !ar_done) begin
        chk("araddr", araddr, cur_addr);
        chk("arprot", arprot, 3'b000);
      end
      if (rsp_pend) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp", rsp_resp, exp_resp);
      end
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (rsp_valid) rsp_hi++;
      if (awvalid && first_aw < 0) first_aw = cyc + 1;
      if (bready && first_br < 0) first_br = cyc + 1;
      if (rsp_valid && rsp_first < 0) rsp_first = cyc + 1;

      // drive inputs for the coming edge
      if (!busy && cmd_q.size() > 0 && gap == 0) begin
        cmd_valid = 1; cmd_write = cmd_q[0].w; cmd_addr = cmd_q[0].a;
        cmd_wdata = cmd_q[0].d; cmd_wstrb = cmd_q[0].s;
      end else begin
        cmd_valid = 0;
        if (gap > 0) gap--;
      end
      awready   = (aw_wait >= d_aw);
      wready    = (w_wait >= d_w);
      arready   = (ar_wait >= d_ar);
      bvalid    = b_armed && (b_wait >= d_b + 1);
      bresp     = cur_bresp;
      rvalid    = r_armed && (r_wait >= d_r + 1);
      rdata     = cur_rdata;
      rresp     = cur_rresp;
      rsp_ready = rsp_pend && (rsp_wait >= d_hold);

      // handshakes that occur at the coming edge
      if (rsp_valid && rsp_ready) begin
        busy = 0; rsp_pend = 0; n_done++;
        last_rsp_rdata = rsp_rdata; last_rsp_resp = rsp_resp;
        last_rsp_hi = rsp_hi; rsp_hs = cyc + 1;
      end else if (rsp_pend) rsp_wait++;
      if (cmd_valid && cmd_ready) begin
        busy = 1; is_wr = cmd_write; cur_addr = cmd_addr;
        cur_wdata = cmd_wdata; cur_wstrb = cmd_wstrb;
        aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; rsp_wait = 0;
        if (cfg_rand) begin
          d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3); d_ar = $urandom_range(0, 3);
          d_b = $urandom_range(0, 3); d_r = $urandom_range(0, 3); d_hold = $urandom_range(0, 3);
          cur_bresp = 2'($urandom_range(0, 3)); cur_rresp = 2'($urandom_range(0, 3));
          cur_rdata = $urandom; gap = $urandom_range(0, 2);
        end else begin
          d_aw = cfg_aw; d_w = cfg_w; d_ar = cfg_ar; d_b = cfg_b; d_r = cfg_r; d_hold = cfg_hold;
          cur_bresp = cfg_bresp; cur_rresp = cfg_rresp; cur_rdata = cfg_rdata;
        end
        accept_gap = (cyc + 1) - rsp_hs;
        accept_edge = cyc + 1; first_aw = -1; first_br = -1; b_hs = -1; rsp_first = -1;
        aw_hi = 0; w_hi = 0; rsp_hi = 0;
        void'(cmd_q.pop_front());
      end
      if (awvalid && awready) begin aw_done = 1; last_awaddr = awaddr; end
      else if (awvalid) aw_wait++;
      if (wvalid && wready) begin w_done = 1; last_wdata = wdata; end
      else if (wvalid) w_wait++;
      if (arvalid && arready) begin ar_done = 1; last_araddr = araddr; end
      else if (arvalid) ar_wait++;
      if (bvalid && bready) begin
        b_done = 1; b_armed = 0; rsp_pend = 1; rsp_wait = 0;
        exp_rdata = '0; exp_resp = cur_bresp; b_hs = cyc + 1;
      end else if (b_armed) b_wait++;
      if (rvalid && rready) begin
        r_done = 1; r_armed = 0; rsp_pend = 1; rsp_wait = 0;
        exp_rdata = cur_rdata; exp_resp = cur_rresp;
      end else if (r_armed) r_wait++;
      if (busy && is_wr && aw_done && w_done && !b_done && !b_armed) begin b_armed = 1; b_wait = 0; end
      if (busy && !is_wr && ar_done && !r_done && !r_armed) begin r_armed = 1; r_wait = 0; end
    end
  end

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_t c;
    c.w = w; c.a = a; c.d = d; c.s = s;
    cmd_q.push_back(c);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (n_done < target) begin
      errors++;
      $display("FAIL %s timeout: responses=%0d expected %0d", name, n_done, target);
    end
  endtask

  task automatic set_zero_wait();
    cfg_rand = 0; cfg_aw = 0; cfg_w = 0; cfg_ar = 0; cfg_b = 0; cfg_r = 0; cfg_hold = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset cmd_ready", cmd_ready, 1'b0);
    chk("reset awvalid", awvalid, 1'b0);
    chk("reset wvalid", wvalid, 1'b0);
    chk("reset arvalid", arvalid, 1'b0);
    chk("reset bready", bready, 1'b0);
    chk("reset rready", rready, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_resp", rsp_resp, 2'b00);
    #1 resetn = 1;
    #1 chk("cmd_ready before first clk", cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("cmd_ready first clk", cmd_ready, 1'b1);
    set_zero_wait();
    run_en = 1;

    // zero-wait write: latency profile
    push_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_done(1, 50, "zero-wait write");
    chk("zw awvalid edge", first_aw - accept_edge, 1);
    chk("zw bready edge", first_br - accept_edge, 2);
    chk("zw b handshake edge", b_hs - accept_edge, 3);
    chk("zw rsp_valid edge", rsp_first - accept_edge, 4);
    chk("zw aw cycles", aw_hi, 1);
    chk("zw w cycles", w_hi, 1);
    chk("zw awaddr", last_awaddr, 32'h10);
    chk("zw wdata", last_wdata, 32'hDEADBEEF);
    chk("zw rsp_resp", last_rsp_resp, 2'b00);
    chk("zw rsp_rdata", last_rsp_rdata, 32'h0);

    // AW delayed 3 cycles, W accepted at once
    cfg_aw = 3;
    push_cmd(1'b1, 32'h20, 32'hA5A5_0F0F, 4'h3);
    wait_done(2, 50, "delayed aw write");
    repeat (5) @(posedge clk);
    chk("dw single response", n_done, 2);
    chk("dw aw cycles", aw_hi, 4);
    chk("dw w cycles", w_hi, 1);
    chk("dw bready edge", first_br - accept_edge, 5);
    cfg_aw = 0;

    // read with SLVERR after two wait cycles
    cfg_r = 2; cfg_rdata = 32'h12345678; cfg_rresp = 2'b10;
    push_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    wait_done(3, 50, "slverr read");
    chk("rd araddr", last_araddr, 32'h24);
    chk("rd rsp_rdata", last_rsp_rdata, 32'h12345678);
    chk("rd rsp_resp", last_rsp_resp, 2'b10);
    set_zero_wait();

    // consumer stalls 5 cycles, next command queued behind it
    cfg_hold = 5; cfg_bresp = 2'b11;
    push_cmd(1'b1, 32'h30, 32'h0BAD_F00D, 4'h8);
    push_cmd(1'b0, 32'h34, 32'h0, 4'h0);
    wait_done(4, 60, "stalled rsp");
    chk("stall rsp_valid cycles", last_rsp_hi, 6);
    chk("stall decerr resp", last_rsp_resp, 2'b11);
    wait_done(5, 60, "after stall");
    chk("stall next accept gap", accept_gap, 1);
    set_zero_wait();

    // reset while AW/W are pending
    cfg_aw = 20; cfg_w = 20;
    push_cmd(1'b1, 32'h40, 32'h1111_2222, 4'hF);
    begin
      int k = 0;
      while (!awvalid && k < 20) begin @(posedge clk); k++; end
    end
    @(posedge clk); #2;
    chk("pre-reset awvalid", awvalid, 1'b1);
    run_en = 0;
    resetn = 0;
    #1;
    chk("async awvalid", awvalid, 1'b0);
    chk("async wvalid", wvalid, 1'b0);
    chk("async cmd_ready", cmd_ready, 1'b0);
    busy = 0; rsp_pend = 0; b_armed = 0; r_armed = 0; cmd_q.delete();
    set_zero_wait();
    repeat (3) begin
      @(posedge clk); #1;
      chk("in-reset rsp_valid", rsp_valid, 1'b0);
      chk("in-reset awvalid", awvalid, 1'b0);
    end
    resetn = 1;
    #1 chk("post-reset cmd_ready early", cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("post-reset cmd_ready", cmd_ready, 1'b1);
    chk("post-reset rsp_valid", rsp_valid, 1'b0);
    run_en = 1;
    repeat (6) @(posedge clk);
    chk("abandoned no response", n_done, 5);

    // randomized traffic
    base = n_done;
    cfg_rand = 1;
    for (int i = 0; i < 60; i++) begin
      push_cmd(1'($urandom_range(0, 1)), {$urandom_range(0, 1023), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
    end
    wait_done(base + 60, 3000, "random traffic");
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
